karatsuba_mult: RTL
===================

KARATSUBA_MULT -- requirements
Module: karatsuba_mult

Interface
REQ-001 SHALL have parameter WID, default 128: operand width; even, >= 16.
REQ-002 SHALL have parameter MLAT, default 12: latency of each half-width sub-multiplier, in clocks.
REQ-003 SHALL have parameter TAGW, default 6: tag width.
REQ-004 SHALL have port rst, input, 1: asynchronous active-high reset.
REQ-005 SHALL have port clk, input, 1: the single clock.
REQ-006 SHALL have port ce, input, 1: pipeline clock enable.
REQ-007 SHALL have port ld, input, 1: operation issue strobe.
REQ-008 SHALL have port mode, input, 2: 00 unsigned, 01 signed x signed, 10 signed a x unsigned b, 11 reserved and treated as 00.
REQ-009 SHALL have port a, input, WID: multiplicand.
REQ-010 SHALL have port b, input, WID: multiplier.
REQ-011 SHALL have port tag_i, input, TAGW: issue tag.
REQ-012 SHALL have port p, output, 2*WID: product.
REQ-013 SHALL have port ovf, output, 1: product does not fit in WID bits.
REQ-014 SHALL have port done, output, 1: p, ovf and tag_o are valid this cycle.
REQ-015 SHALL have port tag_o, output, TAGW: tag of the completing operation.

Function
REQ-016 SHALL sample ld, mode, a, b and tag_i only on clk edges where ce=1.
REQ-017 SHALL assert done exactly L = MLAT+6 enabled (ce=1) clocks after an accepted ld, for one enabled clock.
REQ-018 SHALL freeze every pipeline stage, including valid and tag tracking, on cycles where ce=0; outputs hold.
REQ-019 SHALL accept a new operation on every enabled clock; throughput is one per enabled clock, and up to L operations are in flight.
REQ-020 SHALL complete operations in issue order, each with its own tag, mode and sign.
REQ-021 Stage 1 SHALL take magnitudes: a is negated when mode is 01 or 10 and a[WID-1]=1; b is negated when mode is 01 and b[WID-1]=1; result sign = the XOR of the negated flags.
REQ-022 Stages 2-3 SHALL form d_a = a_lo - a_hi and d_b = b_hi - b_lo as (WID/2+1)-bit signed values, then take their absolute values and record the cross sign.
REQ-023 SHALL compute z2 = a_hi*b_hi, z0 = a_lo*b_lo and z1m = |d_a|*|d_b| using three sub-multiplier instances in parallel.
REQ-024 SHALL form z1 = (+/-)z1m + z2 + z0 at full width, with no truncation of the borrow or carry bit.
REQ-025 SHALL form p = {z2,z0} + (z1 << WID/2), then negate it when the result sign is 1.
REQ-026 ovf SHALL be p[2*WID-1:WID] != 0 in mode 00/11, and SHALL be p[2*WID-1:WID-1] not all-equal in modes 01/10.
REQ-027 Mode 01 with a = b = most-negative SHALL give the exact positive product, with ovf=1.
REQ-028 When done=0, p, ovf and tag_o SHALL hold their last completed values.
REQ-029 ld asserted together with ce=0 SHALL be ignored; no operation is issued.

Reset
REQ-030 While rst=1, p, ovf, done and tag_o SHALL be 0, and all in-flight valid bits SHALL be cleared, regardless of ce.
REQ-031 Operations in flight when rst asserts SHALL be discarded; no done is produced for them after release.
REQ-032 The first enabled clock after rst deasserts SHALL accept ld normally.

Structure
REQ-033 Mode encodings SHALL live in the shared cpu package as named constants: MUL_UU, MUL_SS, MUL_SU.
REQ-034 SHALL instantiate sub-module mult_half three times: an unsigned (WID/2+1)x(WID/2+1) multiplier with latency MLAT and a ce input.
REQ-035 SHALL track valid and tag with a single L-deep shift register gated by ce.

Verification
REQ-036 WID=128, mode 00, a = b = 2^128-1: p = 2^256 - 2^129 + 1, ovf=1, done at L.
REQ-037 Mode 01, a = b = -1: p = 1, ovf=0. Mode 10, a = -1, b = 2: p = 2^256-2 (two's complement -2), ovf=0.
REQ-038 Back-to-back issue of 20 random operations with tags 0..19, each checked against a reference model: 20 consecutive done pulses, tags in order.
REQ-039 ce toggled in a pseudo-random 50% pattern during a stream: results and tags match, and done spacing counts only enabled clocks.
REQ-040 Assert rst with 5 operations in flight: done stays 0 and outputs are 0 during reset; a new op after release completes with a correct result at L.

Source files
------------

// File: rtl/karatsuba_mult_pkg.sv
// Shared multiply definitions: operand mode encodings and the sideband that
// travels alongside each operation through the multiplier pipeline.
package karatsuba_mult_pkg;

  localparam logic [1:0] MUL_UU = 2'b00;
  localparam logic [1:0] MUL_SS = 2'b01;
  localparam logic [1:0] MUL_SU = 2'b10;

  typedef struct packed {
    logic neg;   // final product must be negated
    logic sgd;   // result is interpreted as signed
  } side_t;

  function automatic logic a_is_signed(input logic [1:0] mode);
    return (mode == MUL_SS) || (mode == MUL_SU);
  endfunction

endpackage

// File: rtl/karatsuba_mult_half.sv
// Unsigned W x W multiplier, product retimed through a LAT-deep register chain.
// Latency: LAT enabled clocks, one operand pair accepted per enabled clock.
// Backpressure: none; ce=0 freezes every stage.
module mult_half #(
  parameter int W   = 65,
  parameter int LAT = 12
) (
  input  logic           clk,
  input  logic           ce,
  input  logic [W-1:0]   x,
  input  logic [W-1:0]   y,
  output logic [2*W-1:0] z
);

  logic [2*W-1:0] pipe [LAT];

  always_ff @(posedge clk) begin
    if (ce) begin
      pipe[0] <= x * y;
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign z = pipe[LAT-1];

endmodule

// File: rtl/karatsuba_mult.sv
// Pipelined Karatsuba multiplier with unsigned / signed / mixed-sign modes.
// Latency: MLAT+6 enabled clocks, one new operation per enabled clock.
// Backpressure: none; ce=0 freezes the whole pipeline and holds the outputs.
module karatsuba_mult
  import karatsuba_mult_pkg::*;
#(
  parameter int WID  = 128,
  parameter int MLAT = 12,
  parameter int TAGW = 6
) (
  input  logic             rst,
  input  logic             clk,
  input  logic             ce,
  input  logic             ld,
  input  logic [1:0]       mode,
  input  logic [WID-1:0]   a,
  input  logic [WID-1:0]   b,
  input  logic [TAGW-1:0]  tag_i,
  output logic [2*WID-1:0] p,
  output logic             ovf,
  output logic             done,
  output logic [TAGW-1:0]  tag_o
);

  localparam int H  = WID / 2;
  localparam int L  = MLAT + 6;
  localparam int PW = 2 * WID;
  localparam int ZW = 2 * (H + 1);

  typedef struct packed {
    logic            vld;
    logic [TAGW-1:0] tag;
  } trk_t;

  // Tags only advance with a valid entry, so the last slot keeps the last completed tag.
  trk_t trk [L];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < L; i++) trk[i] <= '0;
    end else if (ce) begin
      trk[0].vld <= ld;
      if (ld) trk[0].tag <= tag_i;
      for (int i = 1; i < L; i++) begin
        trk[i].vld <= trk[i-1].vld;
        if (trk[i-1].vld) trk[i].tag <= trk[i-1].tag;
      end
    end
  end

  assign done  = trk[L-1].vld;
  assign tag_o = trk[L-1].tag;

  logic na, nb;
  assign na = a_is_signed(mode) && a[WID-1];
  assign nb = (mode == MUL_SS) && b[WID-1];

  logic [WID-1:0]     s1_a, s1_b;
  side_t              s1_sd, s2_sd, s3_sd, s4_sd, s5_sd;
  logic [H-1:0]       s2_ah, s2_al, s2_bh, s2_bl, s3_ah, s3_al, s3_bh, s3_bl;
  logic signed [H:0]  s2_da, s2_db;
  logic [H:0]         s3_ma, s3_mb;
  logic               s3_x;
  logic [ZW-1:0]      m_z2, m_z0, m_z1, s4_z2, s4_z0, s4_z1;
  logic [PW-1:0]      s5_p;
  side_t              sd_d [MLAT];
  logic               x_d  [MLAT];

  always_ff @(posedge clk) begin
    if (ce) begin
      s1_a  <= na ? -a : a;
      s1_b  <= nb ? -b : b;
      s1_sd <= '{neg: na ^ nb, sgd: a_is_signed(mode)};

      s2_ah <= s1_a[WID-1:H];
      s2_al <= s1_a[H-1:0];
      s2_bh <= s1_b[WID-1:H];
      s2_bl <= s1_b[H-1:0];
      s2_da <= {1'b0, s1_a[H-1:0]} - {1'b0, s1_a[WID-1:H]};
      s2_db <= {1'b0, s1_b[WID-1:H]} - {1'b0, s1_b[H-1:0]};
      s2_sd <= s1_sd;

      s3_ah <= s2_ah;
      s3_al <= s2_al;
      s3_bh <= s2_bh;
      s3_bl <= s2_bl;
      s3_ma <= s2_da[H] ? -s2_da : s2_da;
      s3_mb <= s2_db[H] ? -s2_db : s2_db;
      s3_x  <= s2_da[H] ^ s2_db[H];
      s3_sd <= s2_sd;

      sd_d[0] <= s3_sd;
      x_d[0]  <= s3_x;
      for (int i = 1; i < MLAT; i++) begin
        sd_d[i] <= sd_d[i-1];
        x_d[i]  <= x_d[i-1];
      end

      // z1 = a_hi*b_lo + a_lo*b_hi never exceeds WID+1 bits, so ZW holds it exactly.
      s4_z2 <= m_z2;
      s4_z0 <= m_z0;
      s4_z1 <= x_d[MLAT-1] ? (m_z2 + m_z0 - m_z1) : (m_z2 + m_z0 + m_z1);
      s4_sd <= sd_d[MLAT-1];

      s5_p  <= (PW'(s4_z2) << WID) + PW'(s4_z0) + (PW'(s4_z1) << H);
      s5_sd <= s4_sd;
    end
  end

  mult_half #(.W(H + 1), .LAT(MLAT)) u_z2 (
    .clk(clk), .ce(ce), .x({1'b0, s3_ah}), .y({1'b0, s3_bh}), .z(m_z2));
  mult_half #(.W(H + 1), .LAT(MLAT)) u_z0 (
    .clk(clk), .ce(ce), .x({1'b0, s3_al}), .y({1'b0, s3_bl}), .z(m_z0));
  mult_half #(.W(H + 1), .LAT(MLAT)) u_z1 (
    .clk(clk), .ce(ce), .x(s3_ma), .y(s3_mb), .z(m_z1));

  logic [PW-1:0] p_fin;
  logic          ovf_fin;
  assign p_fin   = s5_sd.neg ? -s5_p : s5_p;
  assign ovf_fin = s5_sd.sgd ? ~((&p_fin[PW-1:WID-1]) | ~(|p_fin[PW-1:WID-1]))
                             : |p_fin[PW-1:WID];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p   <= '0;
      ovf <= 1'b0;
    end else if (ce && trk[L-2].vld) begin
      p   <= p_fin;
      ovf <= ovf_fin;
    end
  end

endmodule
